sclib_tmr_hsk_tx: RTL and testbench

SCLIB_TMR_HSK_TX -- requirements
Module: sclib_tmr_hsk_tx

---
 rtl/sclib_tmr_hsk_tx.sv | 154 +++++++++++++++
 tb/tb_sclib_tmr_hsk_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sclib_tmr_hsk_tx.sv
// sclib_tmr_hsk_tx -- four-phase handshake transmitter with triple-modular
// redundant control state.
//
// A single-cycle PIN request in IDLE latches DIN onto DOUT and raises REQ.
// The remote side answers on ACK (asynchronous). REQ drops once the
// synchronized ACK is seen high, and BUSY drops once it is seen low again.
// ACK passes through three independent synchronizer chains. The FSM state is
// held in three copies. Both are majority-voted. All copies reload the voted
// next state every cycle, so a single upset is scrubbed within one cycle.
//
// Ports
//   CLK   in   sole clock, posedge
//   SRB   in   async active-low reset
//   PIN   in   single-cycle transfer request
//   DIN   in   [DW] payload, sampled when PIN is accepted
//   ACK   in   remote acknowledge, asynchronous
//   REQ   out  four-phase request level
//   DOUT  out  [DW] payload, held from acceptance until the next acceptance
//   BUSY  out  handshake in progress
//   DROP  out  one-cycle pulse, PIN rejected while busy
//   ERR   out  one-cycle pulse, redundant copy disagreement or illegal state
module sclib_tmr_hsk_tx #(
  parameter int DW    = 8,
  parameter int SYNCC = 2
) (
  input  logic          CLK,
  input  logic          SRB,
  input  logic          PIN,
  input  logic [DW-1:0] DIN,
  input  logic          ACK,
  output logic          REQ,
  output logic [DW-1:0] DOUT,
  output logic          BUSY,
  output logic          DROP,
  output logic          ERR
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    RELEASE = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  // ---------------------------------------------------------------- ACK sync
  (* dont_touch = "true" *) logic [SYNCC-1:0] sync_a;
  (* dont_touch = "true" *) logic [SYNCC-1:0] sync_b;
  (* dont_touch = "true" *) logic [SYNCC-1:0] sync_c;

  always_ff @(posedge CLK or negedge SRB) begin
    if (!SRB) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_c <= '0;
    end else begin
      sync_a <= {sync_a[SYNCC-2:0], ACK};
      sync_b <= {sync_b[SYNCC-2:0], ACK};
      sync_c <= {sync_c[SYNCC-2:0], ACK};
    end
  end

  logic ack_a, ack_b, ack_c, acks;
  logic ack_stable, ack_err;

  assign ack_a = sync_a[SYNCC-1];
  assign ack_b = sync_b[SYNCC-1];
  assign ack_c = sync_c[SYNCC-1];
  assign acks  = (ack_a & ack_b) | (ack_a & ack_c) | (ack_b & ack_c);

  // A chain whose stages all agree has seen the same ACK for SYNCC cycles.
  // Only then is a last-stage mismatch a real fault; otherwise it is just one
  // chain resolving a transition a cycle earlier or later than the others.
  assign ack_stable = ((sync_a == '0) || (sync_a == '1)) &&
                      ((sync_b == '0) || (sync_b == '1)) &&
                      ((sync_c == '0) || (sync_c == '1));
  assign ack_err    = ack_stable &&
                      ((ack_a != acks) || (ack_b != acks) || (ack_c != acks));

  // ------------------------------------------------------------- TMR state
  (* dont_touch = "true" *) logic [1:0] st_a;
  (* dont_touch = "true" *) logic [1:0] st_b;
  (* dont_touch = "true" *) logic [1:0] st_c;

  logic [1:0] st_vote;
  state_t     st_v, st_nx;
  logic       accept, drop_nx, st_bad, copy_err, err_nx;

  assign st_vote  = (st_a & st_b) | (st_a & st_c) | (st_b & st_c);
  assign st_v     = state_t'(st_vote);
  assign copy_err = (st_a != st_vote) || (st_b != st_vote) || (st_c != st_vote);
  assign err_nx   = copy_err | ack_err | st_bad;

  // Every copy reloads the voted next state, which scrubs a flipped copy.
  always_ff @(posedge CLK or negedge SRB) begin
    if (!SRB) begin
      st_a <= IDLE;
      st_b <= IDLE;
      st_c <= IDLE;
    end else begin
      st_a <= st_nx;
      st_b <= st_nx;
      st_c <= st_nx;
    end
  end

  always_comb begin
    st_nx   = IDLE;
    accept  = 1'b0;
    drop_nx = 1'b0;
    st_bad  = 1'b0;
    case (st_v)
      IDLE: begin
        // ACKS high here is a remote protocol violation and is ignored.
        if (PIN) begin
          st_nx  = ASSERT;
          accept = 1'b1;
        end
      end
      ASSERT: begin
        st_nx   = acks ? RELEASE : ASSERT;
        drop_nx = PIN;
      end
      RELEASE: begin
        st_nx   = acks ? RELEASE : IDLE;
        drop_nx = PIN;
      end
      default: begin
        st_nx   = IDLE;
        st_bad  = 1'b1;
        drop_nx = PIN;
      end
    endcase
  end

  // ------------------------------------------------------ registered outputs
  // REQ and BUSY are decoded from the next state, so they change on the same
  // edge as the state itself.
  always_ff @(posedge CLK or negedge SRB) begin
    if (!SRB) begin
      REQ  <= 1'b0;
      BUSY <= 1'b0;
      DOUT <= '0;
      DROP <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      REQ  <= (st_nx == ASSERT);
      BUSY <= (st_nx != IDLE);
      if (accept) DOUT <= DIN;
      DROP <= drop_nx;
      ERR  <= err_nx;
    end
  end

endmodule

// File: tb/tb_sclib_tmr_hsk_tx.sv
// Bench for sclib_tmr_hsk_tx: directed scenarios plus a randomized phase.
// Every cycle is compared against a transaction-level model of the handshake.
module tb_sclib_tmr_hsk_tx;
  localparam int DW    = 8;
  localparam int SYNCC = 2;

  logic          CLK = 1'b0;
  logic          SRB, PIN, ACK;
  logic [DW-1:0] DIN;
  logic          REQ, BUSY, DROP, ERR;
  logic [DW-1:0] DOUT;

  sclib_tmr_hsk_tx #(.DW(DW), .SYNCC(SYNCC)) u_dut (
    .CLK (CLK),
    .SRB (SRB),
    .PIN (PIN),
    .DIN (DIN),
    .ACK (ACK),
    .REQ (REQ),
    .DOUT(DOUT),
    .BUSY(BUSY),
    .DROP(DROP),
    .ERR (ERR)
  );

  always #5 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: ACKS is simply ACK delayed by SYNCC clock edges.
  // The transmitter is busy from acceptance until ACKS has gone high and
  // then low again, and REQ is high until ACKS is first seen high.
  bit             m_req, m_busy, m_drop;
  logic [DW-1:0]  m_dout;
  logic [SYNCC-1:0] ah;
  bit             m_err_exp = 0;
  bit             err_dc    = 0;

  task automatic model_reset();
    m_req = 0; m_busy = 0; m_drop = 0; m_dout = '0; ah = '0;
  endtask

  task automatic step(input string tag = "cyc");
    bit acks;
    @(posedge CLK);
    if (!SRB) model_reset();
    else begin
      acks   = ah[SYNCC-1];
      m_drop = 0;
      if (!m_busy) begin
        if (PIN) begin
          m_busy = 1; m_req = 1; m_dout = DIN;
        end
      end else begin
        m_drop = PIN;
        if (m_req) begin
          if (acks) m_req = 0;
        end else if (!acks) m_busy = 0;
      end
      ah = {ah[SYNCC-2:0], ACK};
    end
    #1;
    chk({tag, ".req"},  REQ,  m_req);
    chk({tag, ".busy"}, BUSY, m_busy);
    chk({tag, ".dout"}, DOUT, m_dout);
    chk({tag, ".drop"}, DROP, m_drop);
    if (!err_dc) chk({tag, ".err"}, ERR, m_err_exp);
  endtask

  task automatic handshake(input logic [DW-1:0] d, input string tag);
    PIN = 1; DIN = d;
    step({tag, "_acc"});
    chk({tag, "_req_hi"}, REQ, 1);
    chk({tag, "_dout"}, DOUT, d);
    PIN = 0;
    ACK = 1;
    repeat (3) step({tag, "_ackhi"});
    chk({tag, "_req_lo"}, REQ, 0);
    ACK = 0;
    repeat (3) step({tag, "_acklo"});
    chk({tag, "_busy_lo"}, BUSY, 0);
  endtask

  initial begin
    SRB = 0; PIN = 0; ACK = 0; DIN = '0;
    model_reset();
    #2;
    chk("rst_req",  REQ,  0);
    chk("rst_busy", BUSY, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_drop", DROP, 0);
    chk("rst_err",  ERR,  0);
    repeat (2) step("rst");
    SRB = 1;
    step("idle");

    // Basic transfer with a rejected second request while busy.
    PIN = 1; DIN = 8'hA5;
    step("a5_acc");
    chk("a5_req", REQ, 1);
    chk("a5_busy", BUSY, 1);
    chk("a5_dout", DOUT, 8'hA5);
    PIN = 1; DIN = 8'h3C;
    step("drop");
    chk("drop_pulse", DROP, 1);
    chk("drop_dout", DOUT, 8'hA5);
    chk("drop_req", REQ, 1);
    PIN = 0;
    step("drop_end");
    chk("drop_once", DROP, 0);
    ACK = 1;
    repeat (3) step("a5_ackhi");
    chk("a5_req_lo", REQ, 0);
    ACK = 0;
    repeat (3) step("a5_acklo");
    chk("a5_busy_lo", BUSY, 0);

    // Request on the very cycle BUSY returned to 0 is accepted.
    PIN = 1; DIN = 8'h5A;
    step("b2b");
    chk("b2b_req", REQ, 1);
    chk("b2b_drop", DROP, 0);
    PIN = 0;
    ACK = 1; repeat (3) step("b2b_ackhi");
    ACK = 0; repeat (3) step("b2b_acklo");

    // Single state-copy upset in IDLE: one ERR pulse, copy scrubbed.
    force u_dut.st_a = 2'b10;
    #1 release u_dut.st_a;
    m_err_exp = 1;
    step("seu_st");
    chk("seu_scrub", u_dut.st_a, 2'b00);
    m_err_exp = 0;
    step("seu_after");

    // One ACK chain stuck high during ASSERT: outvoted, ERR reported.
    PIN = 1; DIN = 8'h77;
    step("seu_ack_acc");
    PIN = 0;
    force u_dut.sync_a = '1;
    m_err_exp = 1;
    repeat (3) step("seu_ack");
    chk("seu_ack_req", REQ, 1);
    release u_dut.sync_a;
    err_dc = 1;
    step("seu_ack_rel");
    err_dc = 0; m_err_exp = 0;
    step("seu_ack_clr");
    ACK = 1; repeat (3) step("seu_ack_hi");
    ACK = 0; repeat (3) step("seu_ack_lo");

    // ACK raised while idle is ignored.
    ACK = 1; repeat (4) step("idle_ack");
    ACK = 0; repeat (3) step("idle_ack_lo");

    // Reset in the middle of a handshake.
    PIN = 1; DIN = 8'hC3;
    step("rst_mid_acc");
    PIN = 0;
    #2 SRB = 0;
    model_reset();
    #1;
    chk("rstmid_req",  REQ,  0);
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_dout", DOUT, 0);
    repeat (2) step("rstmid");
    SRB = 1;
    step("rstmid_rel");
    handshake(8'h01, "post_rst");

    // Randomized traffic with a well-behaved but randomly slow receiver.
    for (int i = 0; i < 400; i++) begin
      PIN = ($urandom_range(0, 3) == 0);
      DIN = DW'($urandom);
      if (REQ && !ACK && $urandom_range(0, 2) == 0) ACK = 1;
      else if (!REQ && ACK && $urandom_range(0, 2) == 0) ACK = 0;
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
